// File: rtl/processor_mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : processor_mem_arb_pkg                                      |
// | Brief    : Shared types and sizes for the on-chip RAM arbiter.        |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package processor_mem_arb_pkg;

  typedef enum logic {
    M_I = 1'b0,
    M_D = 1'b1
  } master_e;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int RD_LATENCY = 1;

endpackage : processor_mem_arb_pkg
`default_nettype wire

// File: rtl/processor_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : processor_rr_arb2                                          |
// | Brief    : Two-requester round-robin grant with last-grant register.  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module processor_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_ifetch_i,
  input  logic req_data_i,
  output logic gnt_ifetch_o,
  output logic gnt_data_o
);
  import processor_mem_arb_pkg::*;

  master_e last_grant_q;
  master_e last_grant_d;

  // On contention the master that did not win last time goes first.
  always_comb begin
    gnt_ifetch_o = ~reset & req_ifetch_i & (~req_data_i | (last_grant_q == M_D));
    gnt_data_o   = ~reset & req_data_i & ~gnt_ifetch_o;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_ifetch_o) begin
      last_grant_d = M_I;
    end else if (gnt_data_o) begin
      last_grant_d = M_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= M_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule : processor_rr_arb2
`default_nettype wire

// File: rtl/processor_onchip_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : processor_onchip_mem_arbiter                               |
// | Brief    : I/D master arbiter in front of a single-port on-chip RAM.  |
// |            Define ARB_CONTENTION_CNT_EN to add a contention counter.  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module processor_onchip_mem_arbiter #(
  parameter int ADDR_W = processor_mem_arb_pkg::ADDR_W,
  parameter int DATA_W = processor_mem_arb_pkg::DATA_W,
  parameter int BE_W   = processor_mem_arb_pkg::BE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_readdatavalid,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [BE_W-1:0]   d_byteenable,
  input  logic [DATA_W-1:0] d_writedata,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef ARB_CONTENTION_CNT_EN
  ,
  output logic [31:0]       contention_cnt
`endif
);
  import processor_mem_arb_pkg::*;

  logic    req_i;
  logic    req_d;
  logic    gnt_i;
  logic    gnt_d;
  logic    rd_pend_q;
  logic    rd_pend_d;
  master_e rd_owner_q;
  master_e rd_owner_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  processor_rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .reset        (reset),
    .req_ifetch_i (req_i),
    .req_data_i   (req_d),
    .gnt_ifetch_o (gnt_i),
    .gnt_data_o   (gnt_d)
  );

  always_comb begin
    i_waitrequest  = ~gnt_i;
    d_waitrequest  = ~gnt_d;
    mem_chipselect = gnt_i | gnt_d;
    mem_write      = gnt_d & d_write;
    mem_address    = gnt_d ? d_address : i_address;
    mem_writedata  = d_writedata;
    mem_byteenable = mem_write ? d_byteenable : {BE_W{1'b1}};
    mem_clken      = 1'b1;
  end

  // A D request with both read and write set is treated as a write.
  always_comb begin
    rd_pend_d  = gnt_i | (gnt_d & ~d_write);
    rd_owner_d = rd_owner_q;
    if (gnt_d) begin
      rd_owner_d = M_D;
    end else if (gnt_i) begin
      rd_owner_d = M_I;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= M_I;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    i_readdatavalid = ~reset & rd_pend_q & (rd_owner_q == M_I);
    d_readdatavalid = ~reset & rd_pend_q & (rd_owner_q == M_D);
    i_readdata      = mem_readdata;
    d_readdata      = mem_readdata;
  end

`ifdef ARB_CONTENTION_CNT_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (req_i & req_d & (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign contention_cnt = cnt_q;
`endif

  a_d_rd_wr_exclusive : assert property (@(posedge clk) disable iff (reset) !(d_read && d_write));

endmodule : processor_onchip_mem_arbiter
`default_nettype wire

// File: tb/tb_processor_onchip_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_processor_onchip_mem_arbiter                            |
// | Brief    : Directed bench with a behavioural 4096x32 RAM model.       |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_processor_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] i_address = '0;
  logic        i_read = 1'b0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        i_readdatavalid;
  logic [11:0] d_address = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [3:0]  d_byteenable = '0;
  logic [31:0] d_writedata = '0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        d_readdatavalid;
  logic [11:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata = '0;
`ifdef ARB_CONTENTION_CNT_EN
  logic [31:0] contention_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [0:4095];

  always #5 clk = ~clk;

  processor_onchip_mem_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .i_address       (i_address),
    .i_read          (i_read),
    .i_waitrequest   (i_waitrequest),
    .i_readdata      (i_readdata),
    .i_readdatavalid (i_readdatavalid),
    .d_address       (d_address),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_byteenable    (d_byteenable),
    .d_writedata     (d_writedata),
    .d_waitrequest   (d_waitrequest),
    .d_readdata      (d_readdata),
    .d_readdatavalid (d_readdatavalid),
    .mem_address     (mem_address),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_clken       (mem_clken),
    .mem_readdata    (mem_readdata)
`ifdef ARB_CONTENTION_CNT_EN
    ,
    .contention_cnt  (contention_cnt)
`endif
  );

  // RAM model: registered q, byte-lane writes, fixed contents reloaded on reset.
  always @(posedge clk) begin
    if (reset) begin
      ram[12'h010] <= 32'hDEAD_BEEF;
      ram[12'h020] <= 32'h0000_0000;
      ram[12'h100] <= 32'hA0A0_0001;
      ram[12'h200] <= 32'hB0B0_0002;
    end
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_read = 1'b1;
    d_read = 1'b1;
    i_address = 12'h010;
    d_address = 12'h100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1 || mem_chipselect !== 1'b0 ||
          mem_write !== 1'b0 || i_readdatavalid !== 1'b0 || d_readdatavalid !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got iw=%b dw=%b cs=%b we=%b iv=%b dv=%b want 1 1 0 0 0 0",
                 c, i_waitrequest, d_waitrequest, mem_chipselect, mem_write,
                 i_readdatavalid, d_readdatavalid);
      end
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (i_waitrequest !== 1'b0 || d_waitrequest !== 1'b1 || mem_chipselect !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant got iw=%b dw=%b cs=%b want 0 1 1",
               i_waitrequest, d_waitrequest, mem_chipselect);
    end
    tick();
    @(negedge clk);
    checks++;
    if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b0 || i_readdatavalid !== 1'b1 ||
        d_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_second_grant got iw=%b dw=%b iv=%b dv=%b want 1 0 1 0",
               i_waitrequest, d_waitrequest, i_readdatavalid, d_readdatavalid);
    end
    tick();
    i_read = 1'b0;
    d_read = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_single_read_i();
    i_read = 1'b1;
    i_address = 12'h010;
    @(negedge clk);
    checks++;
    if (i_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_address !== 12'h010 ||
        mem_byteenable !== 4'hF || mem_write !== 1'b0) begin
      failures++;
      $display("FAIL i_read_issue got iw=%b cs=%b addr=%h be=%h we=%b want 0 1 010 f 0",
               i_waitrequest, mem_chipselect, mem_address, mem_byteenable, mem_write);
    end
    tick();
    i_read = 1'b0;
    @(negedge clk);
    checks++;
    if (i_readdatavalid !== 1'b1 || i_readdata !== 32'hDEAD_BEEF || d_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL i_read_resp got iv=%b data=%h dv=%b want 1 deadbeef 0",
               i_readdatavalid, i_readdata, d_readdatavalid);
    end
    tick();
  endtask

  task automatic test_d_write_read();
    d_write = 1'b1;
    d_address = 12'h020;
    d_writedata = 32'h1122_3344;
    d_byteenable = 4'b0101;
    @(negedge clk);
    checks++;
    if (d_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_byteenable !== 4'b0101 ||
        mem_writedata !== 32'h1122_3344 || mem_address !== 12'h020) begin
      failures++;
      $display("FAIL d_write_issue got dw=%b we=%b be=%b wd=%h addr=%h want 0 1 0101 11223344 020",
               d_waitrequest, mem_write, mem_byteenable, mem_writedata, mem_address);
    end
    tick();
    d_write = 1'b0;
    @(negedge clk);
    checks++;
    if (d_readdatavalid !== 1'b0 || i_readdatavalid !== 1'b0 || mem_chipselect !== 1'b0) begin
      failures++;
      $display("FAIL d_write_noresp got dv=%b iv=%b cs=%b want 0 0 0",
               d_readdatavalid, i_readdatavalid, mem_chipselect);
    end
    tick();
    d_read = 1'b1;
    @(negedge clk);
    checks++;
    if (d_waitrequest !== 1'b0 || mem_byteenable !== 4'hF || mem_write !== 1'b0) begin
      failures++;
      $display("FAIL d_read_issue got dw=%b be=%h we=%b want 0 f 0",
               d_waitrequest, mem_byteenable, mem_write);
    end
    tick();
    d_read = 1'b0;
    @(negedge clk);
    checks++;
    if (d_readdatavalid !== 1'b1 || d_readdata !== 32'h0022_0044 || i_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL d_read_resp got dv=%b data=%h iv=%b want 1 00220044 0",
               d_readdatavalid, d_readdata, i_readdatavalid);
    end
    tick();
  endtask

  task automatic test_contention();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_read = 1'b1;
    d_read = 1'b1;
    i_address = 12'h100;
    d_address = 12'h200;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (i_waitrequest !== (k % 2 == 1) || d_waitrequest !== (k % 2 == 0) ||
          mem_address !== ((k % 2 == 0) ? 12'h100 : 12'h200)) begin
        failures++;
        $display("FAIL contention_grant k=%0d got iw=%b dw=%b addr=%h want iw=%b dw=%b",
                 k, i_waitrequest, d_waitrequest, mem_address, (k % 2 == 1), (k % 2 == 0));
      end
      if (k > 0) begin
        checks++;
        if ((k % 2 == 1) ? (i_readdatavalid !== 1'b1 || d_readdatavalid !== 1'b0 ||
                            i_readdata !== 32'hA0A0_0001)
                         : (d_readdatavalid !== 1'b1 || i_readdatavalid !== 1'b0 ||
                            d_readdata !== 32'hB0B0_0002)) begin
          failures++;
          $display("FAIL contention_resp k=%0d got iv=%b dv=%b id=%h dd=%h want owner=%s",
                   k, i_readdatavalid, d_readdatavalid, i_readdata, d_readdata,
                   (k % 2 == 1) ? "I" : "D");
        end
      end
      tick();
    end
    i_read = 1'b0;
    d_read = 1'b0;
    @(negedge clk);
    checks++;
    if (d_readdatavalid !== 1'b1 || i_readdatavalid !== 1'b0 || d_readdata !== 32'hB0B0_0002) begin
      failures++;
      $display("FAIL contention_last_resp got dv=%b iv=%b dd=%h want 1 0 b0b00002",
               d_readdatavalid, i_readdatavalid, d_readdata);
    end
`ifdef ARB_CONTENTION_CNT_EN
    checks++;
    if (contention_cnt !== 32'd6) begin
      failures++;
      $display("FAIL contention_cnt got %0d want 6", contention_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    i_read = 1'b1;
    i_address = 12'h010;
    @(negedge clk);
    checks++;
    if (i_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL b2b_i_issue got iw=%b want 0", i_waitrequest);
    end
    tick();
    i_read = 1'b0;
    d_write = 1'b1;
    d_address = 12'h005;
    d_writedata = 32'hCAFE_F00D;
    d_byteenable = 4'hF;
    @(negedge clk);
    checks++;
    if (d_waitrequest !== 1'b0 || mem_write !== 1'b1 || i_readdatavalid !== 1'b1 ||
        i_readdata !== 32'hDEAD_BEEF || d_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_write_during_resp got dw=%b we=%b iv=%b id=%h dv=%b want 0 1 1 deadbeef 0",
               d_waitrequest, mem_write, i_readdatavalid, i_readdata, d_readdatavalid);
    end
    tick();
    d_write = 1'b0;
    d_read = 1'b1;
    @(negedge clk);
    checks++;
    if (d_waitrequest !== 1'b0 || mem_write !== 1'b0 || mem_address !== 12'h005 ||
        d_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_read_issue got dw=%b we=%b addr=%h dv=%b want 0 0 005 0",
               d_waitrequest, mem_write, mem_address, d_readdatavalid);
    end
    tick();
    d_read = 1'b0;
    @(negedge clk);
    checks++;
    if (d_readdatavalid !== 1'b1 || d_readdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL b2b_read_resp got dv=%b dd=%h want 1 cafef00d", d_readdatavalid, d_readdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    i_read = 1'b1;
    i_address = 12'h010;
    @(negedge clk);
    checks++;
    if (i_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL midrst_issue got iw=%b want 0", i_waitrequest);
    end
    tick();
    i_read = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (i_readdatavalid !== 1'b0 || d_readdatavalid !== 1'b0 || i_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL midrst_n1 got iv=%b dv=%b iw=%b want 0 0 1",
               i_readdatavalid, d_readdatavalid, i_waitrequest);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (i_readdatavalid !== 1'b0 || d_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_n2 got iv=%b dv=%b want 0 0", i_readdatavalid, d_readdatavalid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read_i();
    test_d_write_read();
    test_contention();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_processor_onchip_mem_arbiter
`default_nettype wire
